// File: rtl/video_pkg.sv
// Shared video types, colour constants and writer FSM states.
// Latency: none, types and constants only.
// Backpressure: none.
package video_pkg;

  // Pixel word, 0x00RRGGBB.
  typedef logic [31:0] pixel_t;

  localparam pixel_t WHITE = 32'h00FF_FFFF;
  localparam pixel_t BLACK = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PAUSE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A pixel lies on the grid when its column or its row is on a grid line.
  function automatic pixel_t grid_pixel(input logic on_col, input logic on_row);
    return (on_col || on_row) ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster walker: x/y counters, byte address pointer, grid pixel and last-pixel flag.
// Latency: outputs describe the current pixel and update on the edge after clr/adv.
// Backpressure: holds while adv is low; clr returns to pixel (0,0).
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; clr restarts the
// raster; adv steps to the next pixel; adr/dat give the current pixel's byte
// address and colour; last is high while the current pixel is the final one.
module pixel_counter
  import video_pkg::*;
#(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          GRID     = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        clr,
  input  logic        adv,
  output logic [31:0] adr,
  output pixel_t      dat,
  output logic        last
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] YLAST = YW'(VDISP - 1);
  // GRID is a power of two, so "mod GRID == 0" is a mask test. If GRID
  // exceeds the counter range the truncated mask is all ones, which still
  // marks only coordinate 0 -- the correct answer in that case.
  localparam logic [XW-1:0] XMASK = XW'(GRID - 1);
  localparam logic [YW-1:0] YMASK = YW'(GRID - 1);

  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;

  always_comb begin
    nx = x;
    ny = y;
    if (clr) begin
      nx = '0;
      ny = '0;
    end else if (x == XLAST) begin
      nx = '0;
      ny = (y == YLAST) ? '0 : y + 1'b1;
    end else begin
      nx = x + 1'b1;
    end
  end

  // Address is a running pointer so no multiplier is needed; colour and the
  // last flag are computed from the next coordinates so every output is a flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x    <= '0;
      y    <= '0;
      adr  <= BASE_ADR;
      dat  <= BLACK;
      last <= 1'b0;
    end else if (clr || adv) begin
      x    <= nx;
      y    <= ny;
      adr  <= clr ? BASE_ADR : adr + 32'd4;
      dat  <= grid_pixel((nx & XMASK) == '0, (ny & YMASK) == '0);
      last <= (nx == XLAST) && (ny == YLAST);
    end
  end

endmodule

// File: rtl/wshb_pattern_writer.sv
// Wishbone pipelined master filling an HDISP x VDISP framebuffer with a grid pattern.
// Latency: first stb one cycle after start; one write per cycle with a zero-wait slave.
// Backpressure: holds stb/adr/dat under stall; caps MAX_OUT unacked writes; yields on request.
//
// Ports: sys_clk, sys_rst_n (async active-low); start pulse begins a fill;
// yield asks for the bus; cyc/stb/we/adr/dat_ms/sel/ack/stall form the
// Wishbone master port; busy spans the fill; done pulses when the last write
// is acknowledged.
// Build option: WSHB_PATTERN_LOOP_EN makes the fill restart at pixel (0,0)
// after every frame without a new start.
module wshb_pattern_writer
  import video_pkg::*;
#(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          GRID     = 16,
  parameter int          MAX_OUT  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        yield,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  input  logic        ack,
  input  logic        stall,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          ack_eff;
  logic          room;
  logic          last;
  logic          clr;

  assign sel = 4'hF;

  assign accept  = stb & ~stall;
  // A stray ack with nothing outstanding is dropped so the count cannot wrap.
  assign ack_eff = ack & (cnt != '0);
  assign cnt_nxt = cnt + CW'(accept) - CW'(ack_eff);
  assign room    = (cnt_nxt < CMAX);

  always_comb begin
    clr = 1'b0;
    if (state == IDLE && start) begin
      clr = 1'b1;
    end
`ifdef WSHB_PATTERN_LOOP_EN
    if (state == DRAIN && cnt_nxt == '0) begin
      clr = 1'b1;
    end
`endif
  end

  pixel_counter #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .BASE_ADR (BASE_ADR),
    .GRID     (GRID)
  ) u_pix (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr),
    .adv       (accept),
    .adr       (adr),
    .dat       (dat_ms),
    .last      (last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cyc   <= 1'b0;
      stb   <= 1'b0;
      we    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      cnt  <= cnt_nxt;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
            cyc   <= 1'b1;
            we    <= 1'b1;
            stb   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (accept && last) begin
            state <= DRAIN;
            stb   <= 1'b0;
          end else if (yield && (!stb || accept)) begin
            // Only leave once nothing is waiting on the slave's stall.
            state <= PAUSE;
            stb   <= 1'b0;
            cyc   <= (cnt_nxt != '0);
            we    <= (cnt_nxt != '0);
          end else begin
            // A stalled request must stay on the bus unchanged.
            stb <= (stb && !accept) || room;
          end
        end
        PAUSE: begin
          stb <= 1'b0;
          if (!yield && cnt == '0) begin
            state <= REQ;
            cyc   <= 1'b1;
            we    <= 1'b1;
            stb   <= 1'b1;
          end else begin
            cyc <= (cnt_nxt != '0);
            we  <= (cnt_nxt != '0);
          end
        end
        DRAIN: begin
          if (cnt_nxt == '0) begin
            done <= 1'b1;
`ifdef WSHB_PATTERN_LOOP_EN
            state <= REQ;
            stb   <= 1'b1;
`else
            state <= IDLE;
            cyc   <= 1'b0;
            we    <= 1'b0;
            busy  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_pattern_writer.sv
// Bench for wshb_pattern_writer: random-stall slave, raster reference model, scoreboard.
// Latency: n/a.
// Backpressure: slave drives random stall and delayed in-order acks.
module tb_wshb_pattern_writer;

  localparam int H    = 160;
  localparam int V    = 90;
  localparam int G    = 16;
  localparam int MAXO = 4;
  localparam int NPIX = H * V;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic        yield     = 1'b0;
  logic        ack       = 1'b0;
  logic        stall     = 1'b0;
  logic        cyc, stb, we, busy, done;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;

  wshb_pattern_writer #(
    .HDISP(H), .VDISP(V), .BASE_ADR(32'h0), .GRID(G), .MAX_OUT(MAXO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .yield(yield),
    .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms), .sel(sel),
    .ack(ack), .stall(stall), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  int          ack_q[$];
  int          cycle_n     = 0;
  int          last_t      = 0;
  bit          rand_mode   = 1'b0;
  int          outst       = 0;
  int          acc_count   = 0;
  int          done_count  = 0;
  int          acc_at_done = 0;
  logic [31:0] last_adr    = 32'h0;
  logic [31:0] adr_at_done = 32'h0;
  logic [31:0] pix [NPIX];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference raster: address and colour from pixel coordinates.
  task automatic push_frame();
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        logic [31:0] a;
        logic [31:0] d;
        a = 32'(4 * (yy * H + xx));
        d = ((xx % G == 0) || (yy % G == 0)) ? 32'h00FF_FFFF : 32'h0;
        exp_q.push_back({a, d});
      end
    end
  endtask

  // Slave: decides stall/ack for the coming edge, schedules in-order acks.
  initial begin
    int t;
    forever begin
      @(posedge sys_clk);
      cycle_n++;
      #1;
      if (!sys_rst_n) begin
        ack_q.delete();
        ack    = 1'b0;
        stall  = 1'b0;
        last_t = 0;
      end else begin
        stall = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        ack   = 1'b0;
        if (ack_q.size() > 0 && ack_q[0] <= cycle_n + 1) begin
          ack = 1'b1;
          void'(ack_q.pop_front());
        end
        if (stb && !stall) begin
          t = cycle_n + 2 + (rand_mode ? int'($urandom_range(0, 5)) : 0);
          if (t <= last_t) t = last_t + 1;
          ack_q.push_back(t);
          last_t = t;
        end
      end
    end
  end

  // Monitor: every write the DUT hands over is popped and compared.
  always @(negedge sys_clk) begin
    int idx;
    if (sys_rst_n) begin
      if (!cyc) check("cyc_low_outstanding", 72'(outst), 72'd0);
      if (done) begin
        done_count++;
        acc_at_done = acc_count;
        adr_at_done = last_adr;
      end
      if (stb && !stall) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got adr %h, expected no write", adr);
        end else begin
          check("write", {3'b0, we, sel, adr, dat_ms}, {3'b0, 1'b1, 4'hF, exp_q.pop_front()});
        end
        acc_count++;
        outst++;
        check("outstanding_max", 72'(outst <= MAXO), 72'd1);
        last_adr = adr;
        idx = int'(adr >> 2);
        if (idx < NPIX) pix[idx] = dat_ms;
      end
      if (ack) outst--;
    end
  end

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_count < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(name, 72'(acc_count >= n), 72'd1);
  endtask

  task automatic wait_done(input int budget, input string name, output int k);
    k = 0;
    do begin
      @(negedge sys_clk);
      #1;
      k++;
    end while (!done && k < budget);
    check(name, 72'(done), 72'd1);
  endtask

  task automatic pulse_start();
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int  k;
    int  base;
    bit  f_stb;
    bit  f_cyc;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cyc",  72'(cyc),    72'd0);
    check("rst_stb",  72'(stb),    72'd0);
    check("rst_we",   72'(we),     72'd0);
    check("rst_adr",  72'(adr),    72'd0);
    check("rst_dat",  72'(dat_ms), 72'd0);
    check("rst_sel",  72'(sel),    72'hF);
    check("rst_busy", 72'(busy),   72'd0);
    check("rst_done", 72'(done),   72'd0);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // Frame 1: zero-wait slave.
    push_frame();
`ifdef WSHB_PATTERN_LOOP_EN
    push_frame();
`endif
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1;
    check("start_latency_stb", 72'(stb), 72'd1);
    check("start_busy", 72'(busy), 72'd1);
    check("first_adr_dat", {8'h0, adr, dat_ms}, {8'h0, 32'h0, 32'h00FF_FFFF});
    start = 1'b0;
    wait_done(20000, "frame1_done", k);
    check("frame1_cycles", 72'(k >= NPIX && k <= NPIX + 10), 72'd1);
    check("frame1_writes", 72'(acc_at_done), 72'(NPIX));
    check("frame1_last_adr", 72'(adr_at_done), 72'h0000_E0FC);
    check("pix_0_0",   72'(pix[0]),          72'h00FF_FFFF);
    check("pix_1_1",   72'(pix[H + 1]),      72'h0);
    check("pix_16_5",  72'(pix[5 * H + 16]), 72'h00FF_FFFF);
    check("pix_17_17", 72'(pix[17 * H + 17]), 72'h0);

`ifdef WSHB_PATTERN_LOOP_EN
    check("loop_busy_held", 72'(busy), 72'd1);
    wait_acc(NPIX + 20, 200, "loop_second_frame");
    check("loop_done_once", 72'(done_count), 72'd1);
    check("loop_frame2_pending", 72'(exp_q.size()), 72'(NPIX - 20));
`else
    check("frame1_busy_low", 72'(busy), 72'd0);
    check("frame1_cyc_low", 72'(cyc), 72'd0);
    @(negedge sys_clk);
    check("frame1_done_once", 72'(done_count), 72'd1);
    check("frame1_queue_empty", 72'(exp_q.size()), 72'd0);

    // Frame 2: random stall and ack delay, ignored start, yield window.
    acc_count  = 0;
    done_count = 0;
    rand_mode  = 1'b1;
    push_frame();
    pulse_start();
    wait_acc(2000, 10000, "rand_reach_2000");
    pulse_start();
    wait_acc(6000, 20000, "rand_reach_6000");
    @(posedge sys_clk);
    #1 rand_mode = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 yield = 1'b1;
    f_stb = 1'b1;
    f_cyc = 1'b1;
    base  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge sys_clk);
      #3;
      if (i == 1) base = acc_count;
      if (stb) f_stb = 1'b0;
      if (i >= 15 && cyc) f_cyc = 1'b0;
    end
    check("yield_stb_low", 72'(f_stb), 72'd1);
    check("yield_cyc_low", 72'(f_cyc), 72'd1);
    check("yield_no_writes", 72'(acc_count), 72'(base));
    yield     = 1'b0;
    rand_mode = 1'b1;
    wait_acc(base + 1, 100, "yield_resume");
    wait_done(60000, "frame2_done", k);
    check("frame2_busy_low", 72'(busy), 72'd0);
    check("frame2_writes", 72'(acc_at_done), 72'(NPIX));
    @(negedge sys_clk);
    check("frame2_done_once", 72'(done_count), 72'd1);
    check("frame2_queue_empty", 72'(exp_q.size()), 72'd0);

    // Frame 3: abandoned by reset at pixel 5000, then a clean restart.
    rand_mode  = 1'b0;
    acc_count  = 0;
    done_count = 0;
    push_frame();
    pulse_start();
    wait_acc(5000, 8000, "reach_5000");
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", 72'(cyc), 72'd0);
    check("rst_mid_stb", 72'(stb), 72'd0);
    check("rst_mid_busy", 72'(busy), 72'd0);
    exp_q.delete();
    repeat (3) @(posedge sys_clk);
    outst     = 0;
    acc_count = 0;
    check("rst_mid_no_done", 72'(done_count), 72'd0);
    #2 sys_rst_n = 1'b1;
    push_frame();
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1;
    check("restart_adr", {39'h0, stb, adr}, {39'h0, 1'b1, 32'h0});
    start = 1'b0;
    wait_done(20000, "frame4_done", k);
    check("frame4_writes", 72'(acc_at_done), 72'(NPIX));
    @(negedge sys_clk);
    check("frame4_done_once", 72'(done_count), 72'd1);
    check("frame4_queue_empty", 72'(exp_q.size()), 72'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
